// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: datapath width, core opcode table and ALU FSM encoding.
package cpu_pkg;

  localparam int unsigned CPU_WIDTH = 16;
  localparam int unsigned CPU_SEL_W = 4;

  localparam logic [CPU_SEL_W-1:0] OP_ADD = 4'd0;
  localparam logic [CPU_SEL_W-1:0] OP_SUB = 4'd1;
  localparam logic [CPU_SEL_W-1:0] OP_MUL = 4'd2;
  localparam logic [CPU_SEL_W-1:0] OP_DIV = 4'd3;
  localparam logic [CPU_SEL_W-1:0] OP_AND = 4'd4;
  localparam logic [CPU_SEL_W-1:0] OP_OR  = 4'd5;
  localparam logic [CPU_SEL_W-1:0] OP_XOR = 4'd6;
  localparam logic [CPU_SEL_W-1:0] OP_LSL = 4'd7;
  localparam logic [CPU_SEL_W-1:0] OP_LSR = 4'd8;
  localparam logic [CPU_SEL_W-1:0] OP_MOV = 4'd11;
  localparam logic [CPU_SEL_W-1:0] OP_CMP = 4'd12;

  typedef enum logic [1:0] {
    ALU_IDLE = 2'd0,
    ALU_ITER = 2'd1,
    ALU_FIN  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between the control FSM (master) and the execute-stage ALU (slave).
interface alu_seq_unit_if #(
  parameter int unsigned WIDTH = cpu_pkg::CPU_WIDTH,
  parameter int unsigned SEL_W = cpu_pkg::CPU_SEL_W
);
  logic             start;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             zero_flag;
  logic             pos_flag;
  logic             div_by_zero;

  modport master (
    output start, alu_sel, a, b,
    input  result, done, busy, zero_flag, pos_flag, div_by_zero
  );

  modport slave (
    input  start, alu_sel, a, b,
    output result, done, busy, zero_flag, pos_flag, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one operand bit per cycle, MSB first.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = cpu_pkg::CPU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] value
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic             running;
  logic             div_q;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   rem;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_acc;
  logic [WIDTH:0]   src_rem;
  logic             src_div;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] bit_pos;
  logic [WIDTH-1:0] mul_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] acc_next;

  // The first bit is processed on the go cycle straight from the inputs, so the
  // final step lands when cnt reaches WIDTH-1.
  always_comb begin
    src_a   = go ? a       : opa;
    src_b   = go ? b       : opb;
    src_acc = go ? '0      : acc;
    src_rem = go ? '0      : rem;
    src_div = go ? is_div  : div_q;
    step    = go ? '0      : CNT_W'(cnt + 1'b1);
    bit_pos = CNT_W'(WIDTH - 1) - step;

    mul_next = {src_acc[WIDTH-2:0], 1'b0} + (src_b[bit_pos] ? src_a : '0);

    rem_sh = {src_rem[WIDTH-1:0], src_a[bit_pos]};
    if (rem_sh >= {1'b0, src_b}) begin
      rem_next = rem_sh - {1'b0, src_b};
      quo_next = {src_acc[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh;
      quo_next = {src_acc[WIDTH-2:0], 1'b0};
    end

    acc_next = src_div ? quo_next : mul_next;
  end

  assign last  = running && (cnt == CNT_W'(WIDTH - 1));
  assign value = acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      running <= 1'b0;
      div_q   <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      rem     <= '0;
    end else if (go) begin
      opa     <= a;
      opb     <= b;
      div_q   <= is_div;
      acc     <= acc_next;
      rem     <= rem_next;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (last) begin
        running <= 1'b0;
      end else begin
        acc <= acc_next;
        rem <= rem_next;
        cnt <= CNT_W'(cnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative MUL/DIV behind a start/busy/done handshake.
module alu_seq_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = cpu_pkg::CPU_WIDTH,
  parameter int unsigned SEL_W = cpu_pkg::CPU_SEL_W
) (
  input  logic       clock,
  input  logic       reset,
  alu_seq_unit_if.slave bus
);
  localparam int unsigned SH_W = $clog2(WIDTH);

  alu_state_e       state;
  logic [WIDTH-1:0] result_q;
  logic             done_q;
  logic             busy_q;
  logic             zero_q;
  logic             pos_q;
  logic             dbz_q;

  logic [WIDTH-1:0] one_res_c;
  logic             one_flags_c;
  logic             one_dbz_c;
  logic             start_iter_c;
  logic             iter_go_c;
  logic [SH_W-1:0]  shamt_c;
  logic             shift_big_c;
  logic             iter_last;
  logic [WIDTH-1:0] iter_value;

  assign shamt_c      = bus.b[SH_W-1:0];
  assign shift_big_c  = |bus.b[WIDTH-1:SH_W];
  assign start_iter_c = (bus.alu_sel == OP_MUL) || ((bus.alu_sel == OP_DIV) && (|bus.b));
  assign iter_go_c    = (state == ALU_IDLE) && bus.start && start_iter_c;

  // Single-cycle results; undefined opcodes fall through and keep result/flags.
  always_comb begin
    one_res_c   = result_q;
    one_flags_c = 1'b0;
    one_dbz_c   = 1'b0;
    case (bus.alu_sel)
      OP_ADD: begin one_res_c = bus.a + bus.b; one_flags_c = 1'b1; end
      OP_SUB: begin one_res_c = bus.a - bus.b; one_flags_c = 1'b1; end
      OP_DIV: begin one_res_c = '1;            one_flags_c = 1'b1; one_dbz_c = 1'b1; end
      OP_AND: begin one_res_c = bus.a & bus.b; one_flags_c = 1'b1; end
      OP_OR:  begin one_res_c = bus.a | bus.b; one_flags_c = 1'b1; end
      OP_XOR: begin one_res_c = bus.a ^ bus.b; one_flags_c = 1'b1; end
      OP_LSL: begin one_res_c = shift_big_c ? '0 : (bus.a << shamt_c); one_flags_c = 1'b1; end
      OP_LSR: begin one_res_c = shift_big_c ? '0 : (bus.a >> shamt_c); one_flags_c = 1'b1; end
      OP_MOV: begin one_res_c = bus.b; end
      OP_CMP: begin one_res_c = bus.a - bus.b; one_flags_c = 1'b1; end
      default: ;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .go     (iter_go_c),
    .is_div (bus.alu_sel == OP_DIV),
    .a      (bus.a),
    .b      (bus.b),
    .last   (iter_last),
    .value  (iter_value)
  );

  // Control FSM; done and div_by_zero are raised on entry to FIN so they coincide with that state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ALU_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      zero_q   <= 1'b1;
      pos_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        ALU_IDLE: begin
          if (bus.start) begin
            if (start_iter_c) begin
              state  <= ALU_ITER;
              busy_q <= 1'b1;
            end else begin
              state    <= ALU_FIN;
              done_q   <= 1'b1;
              dbz_q    <= one_dbz_c;
              result_q <= one_res_c;
              if (one_flags_c) begin
                zero_q <= (one_res_c == '0);
                pos_q  <= (one_res_c != '0) && !one_res_c[WIDTH-1];
              end
            end
          end
        end
        ALU_ITER: begin
          if (iter_last) begin
            state    <= ALU_FIN;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= iter_value;
            zero_q   <= (iter_value == '0);
            pos_q    <= (iter_value != '0) && !iter_value[WIDTH-1];
          end
        end
        ALU_FIN:  state <= ALU_IDLE;
        default:  state <= ALU_IDLE;
      endcase
    end
  end

  assign bus.result      = result_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.zero_flag   = zero_q;
  assign bus.pos_flag    = pos_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed plus randomized checks of alu_seq_unit against an arithmetic reference model.
module tb_alu_seq_unit;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_seq_unit_if bus_if ();

  alu_seq_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] m_res;
  logic        m_zero;
  logic        m_pos;
  logic        m_dbz;
  int          m_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on the opcode table.
  function automatic void model(input logic [3:0] sel, input logic [15:0] av, input logic [15:0] bv);
    int unsigned ua, ub;
    logic [15:0] r;
    bit wr, fl;
    ua = av; ub = bv; wr = 1; fl = 1; m_dbz = 0; m_lat = 1; r = m_res;
    case (sel)
      0:  r = 16'(ua + ub);
      1:  r = 16'(ua - ub);
      2:  begin r = 16'(ua * ub); m_lat = 17; end
      3:  if (ub == 0) begin r = 16'hFFFF; m_dbz = 1; end
          else begin r = 16'(ua / ub); m_lat = 17; end
      4:  r = av & bv;
      5:  r = av | bv;
      6:  r = av ^ bv;
      7:  r = (ub >= 16) ? 16'h0 : 16'(ua << ub);
      8:  r = (ub >= 16) ? 16'h0 : 16'(ua >> ub);
      11: begin r = bv; fl = 0; end
      12: r = 16'(ua - ub);
      default: begin wr = 0; fl = 0; end
    endcase
    if (wr) m_res = r;
    if (fl) begin
      m_zero = (r == 16'h0);
      m_pos  = (r != 16'h0) && !r[15];
    end
  endfunction

  // Issue one op, scramble inputs after start, optionally poke start while busy, then check.
  task automatic run_op(input string tag, input logic [3:0] sel, input logic [15:0] av,
                        input logic [15:0] bv, input bit intrude);
    int lat, busy_cycles, exp_busy;
    model(sel, av, bv);
    exp_busy = (m_lat == 17) ? 16 : 0;
    @(negedge clock);
    bus_if.start = 1'b1; bus_if.alu_sel = sel; bus_if.a = av; bus_if.b = bv;
    @(negedge clock);
    bus_if.start = 1'b0; bus_if.a = 16'($urandom); bus_if.b = 16'($urandom);
    bus_if.alu_sel = 4'($urandom);
    lat = 1; busy_cycles = 0;
    while (!bus_if.done && lat < 40) begin
      if (bus_if.busy) busy_cycles++;
      bus_if.start = intrude && (lat == 4);
      if (bus_if.start) begin bus_if.alu_sel = OP_ADD; bus_if.a = 16'd1; bus_if.b = 16'd1; end
      @(negedge clock);
      lat++;
    end
    bus_if.start = 1'b0;
    chk({tag, ".lat"},  32'(lat), 32'(m_lat));
    chk({tag, ".busy"}, 32'(busy_cycles), 32'(exp_busy));
    chk({tag, ".res"},  32'(bus_if.result), 32'(m_res));
    chk({tag, ".zero"}, 32'(bus_if.zero_flag), 32'(m_zero));
    chk({tag, ".pos"},  32'(bus_if.pos_flag), 32'(m_pos));
    chk({tag, ".dbz"},  32'(bus_if.div_by_zero), 32'(m_dbz));
  endtask

  initial begin
    bit seen;
    logic [3:0] rsel;
    logic [15:0] ra, rb;

    bus_if.start = 1'b0; bus_if.alu_sel = '0; bus_if.a = '0; bus_if.b = '0;
    reset = 1'b1;
    m_res = 16'h0; m_zero = 1'b1; m_pos = 1'b0; m_dbz = 1'b0; m_lat = 1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst.res",  32'(bus_if.result), 32'h0);
    chk("rst.done", 32'(bus_if.done), 32'h0);
    chk("rst.busy", 32'(bus_if.busy), 32'h0);
    chk("rst.zero", 32'(bus_if.zero_flag), 32'h1);
    chk("rst.pos",  32'(bus_if.pos_flag), 32'h0);
    chk("rst.dbz",  32'(bus_if.div_by_zero), 32'h0);

    run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1'b0);

    // Reset in the middle of a MUL aborts it with no done pulse.
    @(negedge clock);
    bus_if.start = 1'b1; bus_if.alu_sel = OP_MUL; bus_if.a = 16'd300; bus_if.b = 16'd300;
    @(negedge clock);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_res = 16'h0; m_zero = 1'b1; m_pos = 1'b0;
    chk("rstmid.res",  32'(bus_if.result), 32'h0);
    chk("rstmid.busy", 32'(bus_if.busy), 32'h0);
    chk("rstmid.done", 32'(bus_if.done), 32'h0);
    chk("rstmid.zero", 32'(bus_if.zero_flag), 32'h1);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clock);
      if (bus_if.done || bus_if.busy) seen = 1'b1;
    end
    chk("rstmid.no_done", 32'(seen), 32'h0);

    run_op("sub_zero", OP_SUB, 16'd5,     16'd5,   1'b0);
    run_op("mul_300",  OP_MUL, 16'd300,   16'd300, 1'b0);
    run_op("div_1000", OP_DIV, 16'd1000,  16'd7,   1'b0);
    run_op("div_zero", OP_DIV, 16'd9,     16'd0,   1'b0);
    run_op("lsl_15",   OP_LSL, 16'h0001,  16'd15,  1'b0);
    run_op("lsr_16",   OP_LSR, 16'h8000,  16'd16,  1'b0);
    run_op("cmp_neg",  OP_CMP, 16'd3,     16'd9,   1'b0);
    run_op("mov_0",    OP_MOV, 16'h1234,  16'd0,   1'b0);
    run_op("undef_9",  4'd9,   16'h00FF,  16'h0F0F, 1'b0);
    run_op("undef_14", 4'd14,  16'h0000,  16'h0000, 1'b0);
    run_op("mul_intr", OP_MUL, 16'd1234,  16'd56,  1'b1);
    run_op("div_intr", OP_DIV, 16'hFFFF,  16'd3,   1'b1);

    // A start presented during the done cycle is dropped.
    run_op("and_fin", OP_AND, 16'hF0F0, 16'h3C3C, 1'b0);
    bus_if.start = 1'b1; bus_if.alu_sel = OP_ADD; bus_if.a = 16'd1; bus_if.b = 16'd1;
    @(negedge clock);
    bus_if.start = 1'b0;
    chk("fin.done_width", 32'(bus_if.done), 32'h0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (bus_if.done) seen = 1'b1;
    end
    chk("fin.ignored", 32'(seen), 32'h0);
    chk("fin.res_hold", 32'(bus_if.result), 32'(m_res));

    for (int i = 0; i < 60; i++) begin
      rsel = 4'($urandom_range(0, 15));
      ra   = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'h0;
        1:       rb = 16'($urandom_range(0, 20));
        default: rb = 16'($urandom);
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, rsel), rsel, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
